// File: rtl/format_decoder.sv
// Three-stage posit decoder: sign/special detect, regime run-length, field split.
// Each stage advances whenever it is empty or the stage after it can take its item.
module format_decoder #(
    parameter int WIDTH = 7,
    parameter int EN    = 1,
    parameter int W_REG = $clog2(WIDTH) + 1,
    parameter int W_EXP = $clog2(WIDTH) + 1,
    parameter int W_MAN = WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_posit,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    n_r,
    output logic signed [W_REG-1:0] regime,
    output logic [W_EXP-1:0]        exponent,
    output logic [W_MAN-1:0]        mantissa,
    output logic                    is_zero,
    output logic                    is_nar
);

    // Handshake: an item moves from stage s to s+1 on a clock edge when
    // valid_s && ready_{s+1}; ready_s = !valid_s || ready_{s+1}; ready after
    // the last stage is out_ready, and in_ready is the first stage's ready.

    localparam int WB        = WIDTH - 1;            // body width (posit minus sign)
    localparam int MAN_SHIFT = W_MAN - WB + EN;

    logic ready1, ready2, ready3;

    // ---------------- stage 1: sign, magnitude, specials ----------------
    logic                    s1_valid;
    logic                    s1_n_r;
    logic [WB-1:0]           s1_body;
    logic                    s1_zero;
    logic                    s1_nar;
    logic [WB-1:0]           body_c;

    // The low WB bits of the full two's complement equal the two's complement of the low bits.
    always_comb begin
        body_c = in_posit[WIDTH-1] ? (~in_posit[WB-1:0] + WB'(1)) : in_posit[WB-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_n_r   <= 1'b0;
            s1_body  <= '0;
            s1_zero  <= 1'b0;
            s1_nar   <= 1'b0;
        end else if (ready1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_n_r  <= in_posit[WIDTH-1];
                s1_body <= body_c;
                s1_zero <= (in_posit == '0);
                s1_nar  <= (in_posit == {1'b1, {WB{1'b0}}});
            end
        end
    end

    // ---------------- stage 2: regime run length ----------------
    logic                    s2_valid;
    logic                    s2_n_r;
    logic signed [W_REG-1:0] s2_regime;
    logic [WB-1:0]           s2_body;
    logic                    s2_zero;
    logic                    s2_nar;

    logic                    r0;
    logic                    run_done;
    int                      run_len;
    int                      k_val;
    logic [WB-1:0]           shifted_c;

    always_comb begin
        r0        = s1_body[WB-1];
        run_done  = 1'b0;
        run_len   = 0;
        k_val     = 0;
        shifted_c = '0;
        for (int i = WB - 1; i >= 0; i--) begin
            if (!run_done && (s1_body[i] == r0)) begin
                run_len = run_len + 1;
            end else begin
                run_done = 1'b1;
            end
        end
        k_val = r0 ? (run_len - 1) : -run_len;
        // Dropping the run plus its terminator leaves nothing once the run reaches WB-1 bits.
        if (run_len < WB - 1) begin
            shifted_c = s1_body << (run_len + 1);
        end
        if (s1_zero || s1_nar) begin
            k_val     = 0;
            shifted_c = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_n_r    <= 1'b0;
            s2_regime <= '0;
            s2_body   <= '0;
            s2_zero   <= 1'b0;
            s2_nar    <= 1'b0;
        end else if (ready2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_n_r    <= s1_n_r;
                s2_regime <= W_REG'(k_val);
                s2_body   <= shifted_c;
                s2_zero   <= s1_zero;
                s2_nar    <= s1_nar;
            end
        end
    end

    // ---------------- stage 3: exponent / fraction split ----------------
    logic [W_EXP-1:0] exp_c;
    logic [W_MAN-1:0] man_c;

    always_comb begin
        exp_c = W_EXP'(s2_body >> (WB - EN));
        man_c = W_MAN'(s2_body) << MAN_SHIFT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            n_r       <= 1'b0;
            regime    <= '0;
            exponent  <= '0;
            mantissa  <= '0;
            is_zero   <= 1'b0;
            is_nar    <= 1'b0;
        end else if (ready3) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                n_r      <= s2_n_r;
                regime   <= s2_regime;
                exponent <= exp_c;
                mantissa <= man_c;
                is_zero  <= s2_zero;
                is_nar   <= s2_nar;
            end
        end
    end

    assign ready3   = !out_valid || out_ready;
    assign ready2   = !s2_valid || ready3;
    assign ready1   = !s1_valid || ready2;
    assign in_ready = ready1;

endmodule

// File: tb/tb_format_decoder.sv
// Bench for format_decoder: expected fields come from a table built by encoding
// every (regime, exponent, fraction) combination into a posit.
module tb_format_decoder;
  localparam int W     = 7;
  localparam int W_REG = 4;
  localparam int W_EXP = 4;
  localparam int W_MAN = 7;
  localparam int FW    = 1 + W_REG + W_EXP + W_MAN + 2;

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [W-1:0]            in_posit;
  logic                    out_valid;
  logic                    out_ready;
  logic                    n_r;
  logic signed [W_REG-1:0] regime;
  logic [W_EXP-1:0]        exponent;
  logic [W_MAN-1:0]        mantissa;
  logic                    is_zero;
  logic                    is_nar;

  format_decoder #(.WIDTH(W), .EN(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_posit(in_posit),
    .out_valid(out_valid), .out_ready(out_ready),
    .n_r(n_r), .regime(regime), .exponent(exponent), .mantissa(mantissa),
    .is_zero(is_zero), .is_nar(is_nar)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [FW-1:0] ref_tab [128];
  bit            filled  [128];
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] cur;
  logic [FW-1:0] held;
  bit            hold_valid = 0;
  bit            rand_ready = 0;

  assign cur = {n_r, regime, exponent, mantissa, is_zero, is_nar};

  function automatic logic [FW-1:0] pack(input logic s, input logic [W_REG-1:0] k,
                                         input logic [W_EXP-1:0] e, input logic [W_MAN-1:0] m,
                                         input logic z, input logic nar);
    return {s, k, e, m, z, nar};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Encoder-direction model: enumerate regime k, then every exponent/fraction
  // pattern that still fits in the 6 body bits.
  task automatic build_table();
    int len, rb, r, eb, fb, body, ex, mn, neg;
    for (int i = 0; i < 128; i++) filled[i] = 0;
    for (int k = -5; k <= 5; k++) begin
      if (k >= 0) begin
        if (k + 1 >= 6) begin len = 6; rb = 63; end
        else begin len = k + 2; rb = ((1 << (k + 1)) - 1) << 1; end
      end else begin
        len = -k + 1; rb = 1;
      end
      r  = 6 - len;
      eb = (r < 1) ? r : 1;
      fb = r - eb;
      for (int e = 0; e < (1 << eb); e++) begin
        for (int f = 0; f < (1 << fb); f++) begin
          body = (rb << r) | (e << fb) | f;
          ex   = e << (1 - eb);
          mn   = (f << (7 - fb)) & 127;
          ref_tab[body] = pack(1'b0, W_REG'(k), W_EXP'(ex), W_MAN'(mn), 1'b0, 1'b0);
          filled[body]  = 1;
          neg = (128 - body) & 127;
          ref_tab[neg] = pack(1'b1, W_REG'(k), W_EXP'(ex), W_MAN'(mn), 1'b0, 1'b0);
          filled[neg]  = 1;
        end
      end
    end
    ref_tab[0]  = pack(1'b0, '0, '0, '0, 1'b1, 1'b0);
    filled[0]   = 1;
    ref_tab[64] = pack(1'b1, '0, '0, '0, 1'b0, 1'b1);
    filled[64]  = 1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_valid = 0;
    end else begin
      if (hold_valid) check("stall_stable", {31'b0, out_valid, 14'b0, cur} >> 0, {31'b1, 1'b1, 14'b0, held} >> 0);
      hold_valid = out_valid && !out_ready;
      held       = cur;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {14'b0, cur}, 32'hFFFF_FFFF);
        end else begin
          check("decode_fields", {14'b0, cur}, {14'b0, exp_q.pop_front()});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_tab[in_posit]);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] x);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_posit = x;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1 for posit %h", x);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: %0d items outstanding, expected 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [W-1:0] dir_vec [7];
  int           order   [128];
  int           nfilled;
  int           j, tmp;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_posit = '0; out_ready = 1'b1;
    build_table();

    nfilled = 0;
    for (int i = 0; i < 128; i++) nfilled += filled[i] ? 1 : 0;
    check("model_coverage", nfilled, 128);
    check("model_0x35", ref_tab[7'h35], pack(1'b0, 4'd1, 4'd1, 7'b0100000, 1'b0, 1'b0));
    check("model_0x4B", ref_tab[7'h4B], pack(1'b1, 4'd1, 4'd1, 7'b0100000, 1'b0, 1'b0));
    check("model_0x0B", ref_tab[7'h0B], pack(1'b0, 4'b1110, 4'd0, 7'b1100000, 1'b0, 1'b0));
    check("model_0x3F", ref_tab[7'h3F], pack(1'b0, 4'd5, 4'd0, 7'd0, 1'b0, 1'b0));
    check("model_0x01", ref_tab[7'h01], pack(1'b0, 4'b1011, 4'd0, 7'd0, 1'b0, 1'b0));
    check("model_0x00", ref_tab[7'h00], pack(1'b0, 4'd0, 4'd0, 7'd0, 1'b1, 1'b0));
    check("model_0x40", ref_tab[7'h40], pack(1'b1, 4'd0, 4'd0, 7'd0, 1'b0, 1'b1));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_state", {out_valid, in_ready, cur}, {1'b0, 1'b1, {FW{1'b0}}});

    // Directed vectors, one at a time
    dir_vec[0] = 7'h35; dir_vec[1] = 7'h4B; dir_vec[2] = 7'h0B; dir_vec[3] = 7'h3F;
    dir_vec[4] = 7'h01; dir_vec[5] = 7'h00; dir_vec[6] = 7'h40;
    for (int i = 0; i < 7; i++) begin
      send(dir_vec[i]);
      drain();
    end

    // Stall: three items fill the pipe, the fourth must wait
    @(posedge clk); #1 out_ready = 1'b0;
    send(7'h35);
    send(7'h0B);
    send(7'h3F);
    in_valid = 1'b1;
    in_posit = 7'h01;
    @(negedge clk);
    check("stall_in_ready_low", in_ready, 1'b0);
    check("stall_out_valid", out_valid, 1'b1);
    @(negedge clk);
    check("stall_in_ready_low2", in_ready, 1'b0);
    @(posedge clk); #1 out_ready = 1'b1;
    send(7'h01);
    drain();

    // Randomized, throttled sweep of every posit in shuffled order
    for (int i = 0; i < 128; i++) order[i] = i;
    for (int i = 127; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    rand_ready = 1;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 128; i++) begin
        send(W'(order[i]));
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
    end
    rand_ready = 0;
    @(posedge clk); #1 out_ready = 1'b1;
    drain();

    // Reset with items in flight: nothing may emerge afterwards
    send(7'h35);
    send(7'h0B);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midreset_state", {out_valid, in_ready}, 2'b01);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midreset_no_stale", out_valid, 1'b0);
    end
    send(7'h4B);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
